// File: rtl/wave_plot_ctrl_pkg.sv
// Shared screen geometry, colour width and controller state encoding for the
// trace-plotting controller and its clear sweep.
package wave_plot_ctrl_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOUR_W = 12;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int GEN_Y_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ARM   = 3'd2,
        ST_DRAW  = 3'd3,
        ST_FLUSH = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Generator Y grows upward while screen rows grow downward; out-of-range Y pins to the top row.
    function automatic logic [Y_W-1:0] map_row(input logic [GEN_Y_W-1:0] y,
                                               input logic [GEN_Y_W-1:0] y_max);
        logic [GEN_Y_W-1:0] y_clamped;
        y_clamped = (y > y_max) ? y_max : y;
        return Y_W'(y_max - y_clamped);
    endfunction

endpackage

// File: rtl/wave_plot_ctrl_if.sv
// Control, generator and framebuffer signals of the trace-plotting controller.
// master = the controller, slave = its surroundings (generator, framebuffer, sequencer).
interface wave_plot_ctrl_if;
    import wave_plot_ctrl_pkg::*;

    logic                start;
    logic [X_W-1:0]      gen_x;
    logic [GEN_Y_W-1:0]  gen_y;
    logic [COLOUR_W-1:0] gen_color;
    logic                gen_finished;
    logic                gen_enable;
    logic                gen_reset;
    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_plot;
    logic                busy;
    logic                done;

    modport master (
        input  start, gen_x, gen_y, gen_color, gen_finished,
        output gen_enable, gen_reset, vga_x, vga_y, vga_colour, vga_plot, busy, done
    );

    modport slave (
        output start, gen_x, gen_y, gen_color, gen_finished,
        input  gen_enable, gen_reset, vga_x, vga_y, vga_colour, vga_plot, busy, done
    );

endinterface

// File: rtl/wave_plot_ctrl_clear_sweep.sv
// Row-major full-screen sweep: one (cx, cy) coordinate per cycle while run_i is high,
// flagging the final pixel so a draw controller can leave its clear state.
module wave_plot_ctrl_clear_sweep
    import wave_plot_ctrl_pkg::*;
#(
    parameter int WIDTH  = SCREEN_W,
    parameter int HEIGHT = SCREEN_H
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           run_i,
    output logic [X_W-1:0] cx_o,
    output logic [Y_W-1:0] cy_o,
    output logic           en_o,
    output logic           last_o
);

    localparam logic [X_W-1:0] CX_LAST = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0] CY_LAST = Y_W'(HEIGHT - 1);

    logic [X_W-1:0] cx_q, cx_d;
    logic [Y_W-1:0] cy_q, cy_d;

    // Counters wrap to (0,0) after the last pixel so the next sweep starts clean.
    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (run_i) begin
            if (cx_q == CX_LAST) begin
                cx_d = '0;
                cy_d = (cy_q == CY_LAST) ? '0 : cy_q + 1'b1;
            end else begin
                cx_d = cx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

    assign cx_o   = cx_q;
    assign cy_o   = cy_q;
    assign en_o   = run_i;
    assign last_o = run_i && (cx_q == CX_LAST) && (cy_q == CY_LAST);

endmodule

// File: rtl/wave_plot_ctrl.sv
// Trace-plotting controller: optional framebuffer clear, generator re-arm, then one
// plot per generator sample with X delayed a cycle to line up with the ROM's Y.
module wave_plot_ctrl
    import wave_plot_ctrl_pkg::*;
#(
    parameter int                  WIDTH          = SCREEN_W,
    parameter int                  HEIGHT         = SCREEN_H,
    parameter logic [COLOUR_W-1:0] BG_COLOUR      = 12'h000,
    parameter bit                  CLEAR_ON_START = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    wave_plot_ctrl_if.master bus
);

    localparam logic [GEN_Y_W-1:0] Y_MAX = GEN_Y_W'(HEIGHT - 1);

    state_e state_q, state_d;

    logic           sweep_en, sweep_last;
    logic [X_W-1:0] sweep_x;
    logic [Y_W-1:0] sweep_y;

    logic gen_enable_s, gen_reset_s, busy_s, done_s;

    logic [X_W-1:0]      samp_x_q;
    logic [COLOUR_W-1:0] samp_c_q;
    logic                samp_valid_q;

    logic [X_W-1:0]      vga_x_q;
    logic [Y_W-1:0]      vga_y_q;
    logic [COLOUR_W-1:0] vga_colour_q;
    logic                vga_plot_q;

    wave_plot_ctrl_clear_sweep #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_sweep (
        .clk    (clk),
        .reset  (reset),
        .run_i  (state_q == ST_CLEAR),
        .cx_o   (sweep_x),
        .cy_o   (sweep_y),
        .en_o   (sweep_en),
        .last_o (sweep_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        gen_enable_s = 1'b0;
        gen_reset_s  = 1'b0;
        busy_s       = 1'b1;
        done_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_s = 1'b0;
                if (bus.start) begin
                    state_d = CLEAR_ON_START ? ST_CLEAR : ST_ARM;
                end
            end
            ST_CLEAR: begin
                if (sweep_last) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                gen_reset_s = 1'b1;
                state_d     = ST_DRAW;
            end
            ST_DRAW: begin
                gen_enable_s = 1'b1;
                if (bus.gen_finished) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done_s  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The ROM answers one cycle after its address, so X and colour wait here for their Y.
    always_ff @(posedge clk) begin
        if (reset) begin
            samp_x_q     <= '0;
            samp_c_q     <= '0;
            samp_valid_q <= 1'b0;
        end else begin
            samp_valid_q <= (state_q == ST_DRAW);
            if (state_q == ST_DRAW) begin
                samp_x_q <= bus.gen_x;
                samp_c_q <= bus.gen_color;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
        end else if (sweep_en) begin
            vga_x_q      <= sweep_x;
            vga_y_q      <= sweep_y;
            vga_colour_q <= BG_COLOUR;
            vga_plot_q   <= 1'b1;
        end else if (samp_valid_q) begin
            vga_x_q      <= samp_x_q;
            vga_y_q      <= map_row(bus.gen_y, Y_MAX);
            vga_colour_q <= samp_c_q;
            vga_plot_q   <= 1'b1;
        end else begin
            vga_plot_q   <= 1'b0;
        end
    end

    assign bus.gen_enable = gen_enable_s;
    assign bus.gen_reset  = gen_reset_s;
    assign bus.busy       = busy_s;
    assign bus.done       = done_s;
    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_colour_q;
    assign bus.vga_plot   = vga_plot_q;

endmodule
